// File: rtl/shift_barrelpipe_rright_pkg.sv
// Shared definitions for the pipelined rotate-right shifter family.
// Provides the amount-width helper and a reference rotate usable by sibling blocks.
package shift_barrelpipe_rright_pkg;

    localparam int unsigned ROT_MAX_BITS = 64;

    // Smallest r with 2**r >= n; gives shift-amount width and pipe depth.
    function automatic int unsigned log2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Rotate the low 'width' bits of value right by amount (modulo width).
    function automatic logic [ROT_MAX_BITS-1:0] rotr(
        input logic [ROT_MAX_BITS-1:0] value,
        input int unsigned             amount,
        input int unsigned             width
    );
        logic [ROT_MAX_BITS-1:0] mask;
        logic [ROT_MAX_BITS-1:0] v;
        int unsigned             amt;
        if (width == 0) begin
            return '0;
        end
        mask = (width >= ROT_MAX_BITS) ? '1 : ((64'(1) << width) - 64'(1));
        v    = value & mask;
        amt  = amount % width;
        if (amt == 0) begin
            return v;
        end
        return ((v >> amt) | (v << (width - amt))) & mask;
    endfunction

endpackage

// File: rtl/shift_barrelpipe_rright_stage.sv
// One register stage of the rotate-right pipe: conditional fixed rotate by 2**Stage
// plus the valid/sh/tag sideband that rides along with the operand.
module shift_rright_stage
    import shift_barrelpipe_rright_pkg::*;
#(
    parameter int unsigned Bits    = 64,
    parameter int unsigned Lg      = 6,
    parameter int unsigned TagBits = 4,
    parameter int unsigned Stage   = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stage_ready,
    input  logic               up_valid,
    input  logic [Bits-1:0]    up_data,
    input  logic [Lg-1:0]      up_sh,
    input  logic [TagBits-1:0] up_tag,
    output logic               dn_valid,
    output logic [Bits-1:0]    dn_data,
    output logic [Lg-1:0]      dn_sh,
    output logic [TagBits-1:0] dn_tag
);

    localparam int unsigned Amt = 2 ** Stage;

    logic               v_q, v_d;
    logic [Bits-1:0]    data_q, data_d;
    logic [Lg-1:0]      sh_q, sh_d;
    logic [TagBits-1:0] tag_q, tag_d;
    logic [Bits-1:0]    rot_w;

    assign rot_w = {up_data[Amt-1:0], up_data[Bits-1:Amt]};

    // Operand regs only move on a real transfer so an empty stage keeps its last value.
    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        sh_d   = sh_q;
        tag_d  = tag_q;
        if (stage_ready) begin
            v_d = up_valid;
            if (up_valid) begin
                data_d = up_sh[Stage] ? rot_w : up_data;
                sh_d   = up_sh;
                tag_d  = up_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= 1'b0;
            data_q <= '0;
            sh_q   <= '0;
            tag_q  <= '0;
        end else begin
            v_q    <= v_d;
            data_q <= data_d;
            sh_q   <= sh_d;
            tag_q  <= tag_d;
        end
    end

    assign dn_valid = v_q;
    assign dn_data  = data_q;
    assign dn_sh    = sh_q;
    assign dn_tag   = tag_q;

endmodule

// File: rtl/shift_barrelpipe_rright.sv
// Pipelined rotate-right barrel shifter: log2(Bits) stages, one register each,
// elastic valid/ready on both ends with a combinational ready chain.
module shift_barrelpipe_rright
    import shift_barrelpipe_rright_pkg::*;
#(
    parameter int unsigned  Bits    = 64,
    parameter int unsigned  TagBits = 4,
    localparam int unsigned Lg      = log2(Bits)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Bits-1:0]    in_a,
    input  logic [Lg-1:0]      in_sh,
    input  logic [TagBits-1:0] in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [Bits-1:0]    out_b,
    output logic [TagBits-1:0] out_tag
);

    // Index k is the input of stage k; index Lg is the output of the last stage.
    logic [Lg:0]        vld_w;
    logic [Lg:0]        rdy_w;
    logic [Bits-1:0]    data_w [0:Lg];
    logic [Lg-1:0]      sh_w   [0:Lg];
    logic [TagBits-1:0] tag_w  [0:Lg];
    logic               unused_sh_w;

    assign vld_w[0]  = in_valid;
    assign data_w[0] = in_a;
    assign sh_w[0]   = in_sh;
    assign tag_w[0]  = in_tag;

    // A stage can take new data when it is empty or its successor takes its data.
    always_comb begin
        rdy_w     = '0;
        rdy_w[Lg] = out_ready;
        for (int k = Lg - 1; k >= 0; k--) begin
            rdy_w[k] = !vld_w[k+1] | rdy_w[k+1];
        end
    end

    for (genvar k = 0; k < Lg; k++) begin : g_stage
        shift_rright_stage #(
            .Bits    (Bits),
            .Lg      (Lg),
            .TagBits (TagBits),
            .Stage   (k)
        ) u_stage (
            .clk         (clk),
            .reset_n     (reset_n),
            .stage_ready (rdy_w[k]),
            .up_valid    (vld_w[k]),
            .up_data     (data_w[k]),
            .up_sh       (sh_w[k]),
            .up_tag      (tag_w[k]),
            .dn_valid    (vld_w[k+1]),
            .dn_data     (data_w[k+1]),
            .dn_sh       (sh_w[k+1]),
            .dn_tag      (tag_w[k+1])
        );
    end

    assign in_ready    = rdy_w[0];
    assign out_valid   = vld_w[Lg];
    assign out_b       = data_w[Lg];
    assign out_tag     = tag_w[Lg];
    assign unused_sh_w = ^sh_w[Lg];

endmodule

// File: tb/tb_shift_barrelpipe_rright.sv
// Bench for the pipelined rotate-right shifter: queue-based scoreboard fed on accept,
// drained on output, with directed, back-to-back, stall, random and mid-flight reset cases.
module tb_shift_barrelpipe_rright;

    localparam int LG = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] in_a, out_b;
    logic [5:0]  in_sh;
    logic [3:0]  in_tag, out_tag;

    typedef struct {
        logic [63:0] b;
        logic [3:0]  tag;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    bit          lat_en = 1'b0;
    logic [63:0] drv_exp = '0;
    bit          hold_pend = 1'b0;
    logic [63:0] hold_b;
    logic [3:0]  hold_tag;

    always #5 clk = ~clk;

    shift_barrelpipe_rright #(.Bits(64), .TagBits(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_sh     (in_sh),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_tag   (out_tag)
    );

    task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_rotr(input logic [63:0] a, input int sh);
        if (sh == 0) return a;
        return (a >> sh) | (a << (64 - sh));
    endfunction

    // Monitor: values seen at the falling edge are the ones the next rising edge samples.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!reset_n) begin
            sb_q.delete();
            hold_pend = 1'b0;
        end else begin
            if (out_valid && hold_pend) begin
                chk_val("hold_b", out_b, hold_b);
                chk_val("hold_tag", 64'(out_tag), 64'(hold_tag));
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk_val("spurious_out", 64'(1), 64'(0));
                end else begin
                    e = sb_q.pop_front();
                    chk_val("out_b", out_b, e.b);
                    chk_val("out_tag", 64'(out_tag), 64'(e.tag));
                    if (e.lat) chk_val("latency", 64'(cyc - e.cyc), 64'(LG));
                end
            end
            hold_pend = out_valid && !out_ready;
            hold_b    = out_b;
            hold_tag  = out_tag;
            if (in_valid && in_ready) begin
                e.b   = drv_exp;
                e.tag = in_tag;
                e.cyc = cyc;
                e.lat = lat_en;
                sb_q.push_back(e);
            end
        end
    end

    // Drive one cycle (called at posedge+1); reports whether the op was accepted.
    task automatic step(input bit v, input logic [63:0] a, input logic [5:0] sh,
                        input logic [3:0] tag, input logic [63:0] exp, input bit ordy,
                        output bit acc, output bit rdy_s);
        in_valid  = v;
        in_a      = a;
        in_sh     = sh;
        in_tag    = tag;
        drv_exp   = exp;
        out_ready = ordy;
        @(negedge clk);
        rdy_s = in_ready;
        acc   = v && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] a, input logic [5:0] sh, input logic [3:0] tag,
                        input logic [63:0] exp, input bit ordy);
        bit acc, r;
        int n;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 100) begin
            step(1'b1, a, sh, tag, exp, ordy, acc, r);
            n++;
        end
        if (!acc) chk_val("send_timeout", 64'(0), 64'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit a, r;
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            step(1'b0, '0, '0, '0, '0, 1'b1, a, r);
            n++;
        end
        chk_val("drain_empty", 64'(sb_q.size()), 64'(0));
        chk_val("drain_out_valid", 64'(out_valid), 64'(0));
    endtask

    initial begin
        bit          acc, rdy;
        bit          pend;
        int          acc_cnt;
        logic [63:0] pa;
        logic [5:0]  ps;
        logic [3:0]  pt;

        reset_n   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_sh     = '0;
        in_tag    = '0;
        #1 reset_n = 1'b0;
        #2;
        chk_val("rst_out_valid", 64'(out_valid), 64'(0));
        chk_val("rst_out_b", out_b, 64'(0));
        chk_val("rst_out_tag", 64'(out_tag), 64'(0));
        chk_val("rst_in_ready", 64'(in_ready), 64'(1));
        #19 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk_val("post_rst_out_valid", 64'(out_valid), 64'(0));

        // Directed vectors with fixed expected results.
        lat_en = 1'b1;
        send(64'h0123_4567_89AB_CDEF, 6'd4, 4'd3, 64'hF012_3456_789A_BCDE, 1'b1);
        drain();
        send(64'h8000_0000_0000_0001, 6'd0, 4'd5, 64'h8000_0000_0000_0001, 1'b1);
        send(64'h8000_0000_0000_0001, 6'd63, 4'd6, 64'h0000_0000_0000_0003, 1'b1);
        send(64'hFFFF_0000_0000_0000, 6'd32, 4'd7, 64'h0000_0000_FFFF_0000, 1'b1);
        drain();

        // Back-to-back: one accept per cycle, fixed latency.
        acc_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            pa = {$urandom, $urandom};
            ps = 6'($urandom_range(0, 63));
            pt = 4'(i);
            step(1'b1, pa, ps, pt, ref_rotr(pa, int'(ps)), 1'b1, acc, rdy);
            if (acc) acc_cnt++;
        end
        chk_val("b2b_accepts", 64'(acc_cnt), 64'(100));
        drain();

        // Stall: output blocked, pipe fills after six accepts.
        lat_en  = 1'b0;
        acc_cnt = 0;
        pa = {$urandom, $urandom};
        ps = 6'($urandom_range(0, 63));
        pt = 4'(acc_cnt);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, pa, ps, pt, ref_rotr(pa, int'(ps)), 1'b0, acc, rdy);
            chk_val("stall_in_ready", 64'(rdy), 64'(acc_cnt < 6));
            if (acc) begin
                acc_cnt++;
                pa = {$urandom, $urandom};
                ps = 6'($urandom_range(0, 63));
                pt = 4'(acc_cnt);
            end
        end
        chk_val("stall_accepts", 64'(acc_cnt), 64'(6));
        drain();

        // Random valid/ready toggling; data held steady while an offer is pending.
        pend = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            bit ordy;
            if (!pend && ($urandom_range(0, 1) == 1)) begin
                pend = 1'b1;
                pa   = {$urandom, $urandom};
                ps   = 6'($urandom_range(0, 63));
                pt   = 4'($urandom_range(0, 15));
            end
            ordy = 1'($urandom_range(0, 1));
            step(pend, pa, ps, pt, ref_rotr(pa, int'(ps)), ordy, acc, rdy);
            if (ordy) chk_val("no_bubble_in_ready", 64'(rdy), 64'(1));
            if (acc) pend = 1'b0;
        end
        drain();

        // Reset with four ops in flight and the output stalled.
        for (int i = 0; i < 4; i++) begin
            pa = {$urandom, $urandom};
            ps = 6'($urandom_range(1, 63));
            send(pa, ps, 4'(i + 8), ref_rotr(pa, int'(ps)), 1'b0);
        end
        for (int i = 0; i < 3; i++) step(1'b0, '0, '0, '0, '0, 1'b0, acc, rdy);
        chk_val("pre_rst_out_valid", 64'(out_valid), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk_val("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk_val("mid_rst_out_b", out_b, 64'(0));
        chk_val("mid_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) step(1'b0, '0, '0, '0, '0, 1'b1, acc, rdy);
        chk_val("post_mid_rst_out_valid", 64'(out_valid), 64'(0));
        lat_en = 1'b1;
        send(64'hFEDC_BA98_7654_3210, 6'd8, 4'd9, 64'h10FE_DCBA_9876_5432, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
